// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT front-end loader.
package ntt_pkg;

  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned BN      = 16;
  localparam int unsigned MA      = 256;
  localparam int unsigned ADDR_W  = $clog2(MA);
  localparam int unsigned COL_W   = $clog2(BN);

  // Prime modulus used by the benches (2^27 * 5 / 4 + 1 style NTT-friendly prime).
  localparam logic [D_WIDTH-1:0] TB_MODULUS = 32'd167772161;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/ntt_coef_reduce.sv
// Conditional single subtract of the modulus with an out-of-range flag.
// Only built when NTT_LOADER_RANGE_CHECK_EN is defined.
`ifdef NTT_LOADER_RANGE_CHECK_EN
module ntt_coef_reduce
  import ntt_pkg::*;
(
  input  logic [D_WIDTH-1:0] data_i,
  input  logic [D_WIDTH-1:0] modulus_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic               over_o
);

  assign over_o = (data_i >= modulus_i);
  assign data_o = over_o ? (data_i - modulus_i) : data_i;

endmodule
`endif

// File: rtl/ntt_coef_loader.sv
// Packs a serial coefficient stream into BN-wide rows written to all banks at once.
// Optional input reduction and range_err flag enabled by NTT_LOADER_RANGE_CHECK_EN.
module ntt_coef_loader
  import ntt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [D_WIDTH-1:0]    modulus,
  input  logic                  in_valid,
  input  logic [D_WIDTH-1:0]    in_data,
  output logic                  in_ready,
  output logic [BN-1:0]         mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [BN*D_WIDTH-1:0] mem_wdata,
  output logic                  load_done,
  output logic                  range_err
);

  loader_state_t          state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]      row_q, row_d;
  logic                   mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [BN*D_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   load_done_q, load_done_d;
  logic                   range_err_q, range_err_d;
  logic [D_WIDTH-1:0]     row_buf_q [BN-1];

  logic                   beat;
  logic                   col_last;
  logic                   row_last;
  logic [D_WIDTH-1:0]     coef;
  logic                   coef_over;

`ifdef NTT_LOADER_RANGE_CHECK_EN
  ntt_coef_reduce u_reduce (
    .data_i    (in_data),
    .modulus_i (modulus),
    .data_o    (coef),
    .over_o    (coef_over)
  );
`else
  logic unused_modulus;
  assign unused_modulus = ^modulus;
  assign coef           = in_data;
  assign coef_over      = 1'b0;
`endif

  assign in_ready = (state_q == FILL);
  assign beat     = in_valid && in_ready;
  assign col_last = (col_q == COL_W'(BN - 1));
  assign row_last = (row_q == ADDR_W'(MA - 1));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = load_done_q;
    range_err_d = range_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          col_d       = '0;
          row_d       = '0;
          load_done_d = 1'b0;
          range_err_d = 1'b0;
        end
      end

      FILL: begin
        if (beat) begin
          if (coef_over) begin
            range_err_d = 1'b1;
          end
          // The last coefficient of a row bypasses row_buf so the next row fills without a bubble.
          if (col_last) begin
            mem_wen_d  = 1'b1;
            mem_addr_d = row_q;
            for (int b = 0; b < BN - 1; b++) begin
              mem_wdata_d[b*D_WIDTH +: D_WIDTH] = row_buf_q[b];
            end
            mem_wdata_d[(BN-1)*D_WIDTH +: D_WIDTH] = coef;
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_last) begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      DONE: begin
        // First DONE cycle is the final write cycle, so load_done trails it by one.
        load_done_d = 1'b1;
        if (start) begin
          state_d     = FILL;
          col_d       = '0;
          row_d       = '0;
          load_done_d = 1'b0;
          range_err_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      range_err_q <= range_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat && !col_last) begin
      row_buf_q[col_q] <= coef;
    end
  end

  assign mem_wen   = {BN{mem_wen_q}};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign load_done = load_done_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Directed self-checking bench for ntt_coef_loader with a bank memory model.
module tb_ntt_coef_loader;
  import ntt_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [D_WIDTH-1:0]    modulus;
  logic                  in_valid;
  logic [D_WIDTH-1:0]    in_data;
  logic                  in_ready;
  logic [BN-1:0]         mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BN*D_WIDTH-1:0] mem_wdata;
  logic                  load_done;
  logic                  range_err;

  int vectors;
  int miscompares;

  int                cycleCount;
  int                pulseCount;
  int                badWen;
  int                pulseCycle [MA];
  logic [ADDR_W-1:0] pulseAddr  [MA];
  logic [D_WIDTH-1:0] bankMem   [BN][MA];
  logic              clearMem;

  ntt_coef_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .modulus   (modulus),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .load_done (load_done),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM bank model plus a log of every write pulse.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (clearMem) begin
      pulseCount <= 0;
      badWen     <= 0;
      for (int b = 0; b < BN; b++)
        for (int k = 0; k < MA; k++)
          bankMem[b][k] <= '0;
    end else if (mem_wen != '0) begin
      if (mem_wen !== '1) badWen <= badWen + 1;
      if (pulseCount < MA) begin
        pulseCycle[pulseCount] <= cycleCount;
        pulseAddr[pulseCount]  <= mem_addr;
      end
      pulseCount <= pulseCount + 1;
      for (int b = 0; b < BN; b++)
        bankMem[b][mem_addr] <= mem_wdata[b*D_WIDTH +: D_WIDTH];
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task doReset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task clearModel;
    clearMem = 1'b1;
    tick;
    clearMem = 1'b0;
  endtask

  task pulseStart;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task driveBeats(input int count, input int base);
    for (int n = 0; n < count; n++) begin
      in_valid = 1'b1;
      in_data  = D_WIDTH'(base + n);
      tick;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    tick; tick;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (mem_wen !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_wen got %h want 0", mem_wen); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got %0d want 0", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata got nonzero want 0"); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_done got %b want 0", load_done); end
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_range_err got %b want 0", range_err); end
    rst = 1'b0;
    tick;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_in_ready got %b want 0", in_ready); end
  endtask

  task test_full_rate;
    int c0, bad, badSpace, badAddr;
    clearModel;
    pulseStart;
    c0 = cycleCount;
    driveBeats(MA*BN, 0);
    // One cycle past the final beat: last write presented, done not yet.
    vectors++; if (mem_wen !== '1 || mem_addr !== ADDR_W'(MA-1)) begin miscompares++; $display("[TB] FAIL full_last_write got wen=%h addr=%0d want all-ones/255", mem_wen, mem_addr); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_early got %b want 0", load_done); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready_done got %b want 0", in_ready); end
    tick;
    vectors++; if (load_done !== 1'b1) begin miscompares++; $display("[TB] FAIL full_load_done got %b want 1", load_done); end
    vectors++; if (mem_wen !== '0) begin miscompares++; $display("[TB] FAIL full_wen_after got %h want 0", mem_wen); end
    vectors++; if (pulseCount !== MA) begin miscompares++; $display("[TB] FAIL full_pulse_count got %0d want %0d", pulseCount, MA); end
    vectors++; if (badWen !== 0) begin miscompares++; $display("[TB] FAIL full_partial_wen got %0d want 0", badWen); end
    vectors++; if (pulseCycle[0] !== c0 + BN) begin miscompares++; $display("[TB] FAIL full_first_pulse got %0d want %0d", pulseCycle[0] - c0, BN); end
    badSpace = 0; badAddr = 0;
    for (int k = 0; k < MA; k++) begin
      if (pulseAddr[k] !== ADDR_W'(k)) badAddr++;
      if (k > 0 && pulseCycle[k] - pulseCycle[k-1] != BN) badSpace++;
    end
    vectors++; if (badSpace !== 0) begin miscompares++; $display("[TB] FAIL full_spacing got %0d bad gaps want 0", badSpace); end
    vectors++; if (badAddr !== 0) begin miscompares++; $display("[TB] FAIL full_addr_seq got %0d bad addrs want 0", badAddr); end
    bad = 0;
    for (int k = 0; k < MA; k++)
      for (int b = 0; b < BN; b++)
        if (bankMem[b][k] !== D_WIDTH'(k*BN + b)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL full_bank_data got %0d bad words want 0", bad); end
  endtask

  task test_backpressure_end;
    int readyHigh;
    clearModel;
    readyHigh = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd9999;
      tick;
      if (in_ready !== 1'b0) readyHigh++;
    end
    in_valid = 1'b0;
    vectors++; if (readyHigh !== 0) begin miscompares++; $display("[TB] FAIL end_in_ready got %0d high cycles want 0", readyHigh); end
    vectors++; if (pulseCount !== 0) begin miscompares++; $display("[TB] FAIL end_no_wen got %0d pulses want 0", pulseCount); end
    vectors++; if (mem_addr !== ADDR_W'(MA-1)) begin miscompares++; $display("[TB] FAIL end_addr got %0d want 255", mem_addr); end
    vectors++; if (load_done !== 1'b1) begin miscompares++; $display("[TB] FAIL end_done_held got %b want 1", load_done); end
  endtask

  task test_start_in_done;
    int bad;
    clearModel;
    pulseStart;
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_done_clear got %b want 0", load_done); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_ready got %b want 1", in_ready); end
    driveBeats(BN, 3000);
    tick;
    vectors++; if (pulseCount !== 1 || pulseAddr[0] !== '0) begin miscompares++; $display("[TB] FAIL restart_pulse got %0d pulses addr %0d want 1/0", pulseCount, pulseAddr[0]); end
    bad = 0;
    for (int b = 0; b < BN; b++) if (bankMem[b][0] !== D_WIDTH'(3000 + b)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL restart_row0 got %0d bad words want 0", bad); end
    doReset;
  endtask

  task test_stalls;
    int beats, earlyWen, bad, i;
    logic v;
    clearModel;
    pulseStart;
    beats = 0; earlyWen = 0; i = 0;
    while (beats < 3*BN) begin
      v = ((i % 4) == 0) || ((i % 4) == 3);
      in_valid = v;
      in_data  = v ? D_WIDTH'(5000 + beats) : 32'hDEAD_BEEF;
      tick;
      if (v) beats++;
      if (beats == BN && v) begin
        vectors++; if (mem_wen !== '1 || mem_addr !== '0) begin miscompares++; $display("[TB] FAIL stall_row0_write got wen=%h addr=%0d want all-ones/0", mem_wen, mem_addr); end
      end else if (beats < BN && mem_wen !== '0) begin
        earlyWen++;
      end
      i++;
    end
    in_valid = 1'b0;
    tick;
    vectors++; if (earlyWen !== 0) begin miscompares++; $display("[TB] FAIL stall_early_wen got %0d want 0", earlyWen); end
    vectors++; if (pulseCount !== 3) begin miscompares++; $display("[TB] FAIL stall_pulse_count got %0d want 3", pulseCount); end
    bad = 0;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < BN; b++)
        if (bankMem[b][k] !== D_WIDTH'(5000 + k*BN + b)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL stall_bank_data got %0d bad words want 0", bad); end
    doReset;
  endtask

  task test_reset_midload;
    int bad;
    clearModel;
    pulseStart;
    driveBeats(40, 7000);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd7040;
    tick;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_ready got %b want 0", in_ready); end
    vectors++; if (mem_wen !== '0) begin miscompares++; $display("[TB] FAIL rstmid_wen got %h want 0", mem_wen); end
    rst = 1'b0;
    tick;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_idle got %b want 0", in_ready); end
    in_valid = 1'b0;
    clearModel;
    pulseStart;
    driveBeats(2*BN, 8000);
    tick;
    vectors++; if (pulseCount !== 2 || pulseAddr[0] !== 8'd0 || pulseAddr[1] !== 8'd1) begin miscompares++; $display("[TB] FAIL rstmid_reload_pulses got %0d pulses addr %0d,%0d want 2/0,1", pulseCount, pulseAddr[0], pulseAddr[1]); end
    bad = 0;
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < BN; b++)
        if (bankMem[b][k] !== D_WIDTH'(8000 + k*BN + b)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL rstmid_reload_data got %0d bad words want 0", bad); end
    doReset;
  endtask

  task test_ignored_start;
    int bad, readyDrop;
    clearModel;
    pulseStart;
    readyDrop = 0;
    for (int n = 0; n < BN; n++) begin
      start    = (n == 5);
      in_valid = 1'b1;
      in_data  = D_WIDTH'(2000 + n);
      tick;
      if (n < BN - 1 && in_ready !== 1'b1) readyDrop++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    tick;
    vectors++; if (readyDrop !== 0) begin miscompares++; $display("[TB] FAIL ignstart_ready got %0d drops want 0", readyDrop); end
    vectors++; if (pulseCount !== 1 || pulseAddr[0] !== '0) begin miscompares++; $display("[TB] FAIL ignstart_pulse got %0d pulses addr %0d want 1/0", pulseCount, pulseAddr[0]); end
    bad = 0;
    for (int b = 0; b < BN; b++) if (bankMem[b][0] !== D_WIDTH'(2000 + b)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL ignstart_row0 got %0d bad words want 0", bad); end
    doReset;
  endtask

  task test_range;
    logic [D_WIDTH-1:0] exp3, exp5;
    logic               expErr;
`ifdef NTT_LOADER_RANGE_CHECK_EN
    exp3 = 32'd4; exp5 = 32'd0; expErr = 1'b1;
`else
    exp3 = 32'd167772165; exp5 = 32'd167772161; expErr = 1'b0;
`endif
    clearModel;
    pulseStart;
    for (int n = 0; n < BN; n++) begin
      in_valid = 1'b1;
      in_data  = (n == 3) ? 32'd167772165 : (n == 5) ? 32'd167772161 : D_WIDTH'(n);
      tick;
      if (n == 2) begin
        vectors++; if (range_err !== 1'b0) begin miscompares++; $display("[TB] FAIL range_err_before got %b want 0", range_err); end
      end
      if (n == 3) begin
        vectors++; if (range_err !== expErr) begin miscompares++; $display("[TB] FAIL range_err_set got %b want %b", range_err, expErr); end
      end
    end
    in_valid = 1'b0;
    tick;
    vectors++; if (range_err !== expErr) begin miscompares++; $display("[TB] FAIL range_err_sticky got %b want %b", range_err, expErr); end
    vectors++; if (bankMem[3][0] !== exp3) begin miscompares++; $display("[TB] FAIL range_bank3 got %0d want %0d", bankMem[3][0], exp3); end
    vectors++; if (bankMem[5][0] !== exp5) begin miscompares++; $display("[TB] FAIL range_bank5 got %0d want %0d", bankMem[5][0], exp5); end
    vectors++; if (bankMem[4][0] !== 32'd4) begin miscompares++; $display("[TB] FAIL range_bank4 got %0d want 4", bankMem[4][0]); end
    doReset;
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("[TB] FAIL range_err_reset got %b want 0", range_err); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleCount  = 0;
    pulseCount  = 0;
    badWen      = 0;
    clearMem    = 1'b0;
    modulus     = TB_MODULUS;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset;
    test_full_rate;
    test_backpressure_end;
    test_start_in_done;
    test_stalls;
    test_reset_midload;
    test_ignored_start;
    test_range;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
